// File: rtl/seq_add_accum_pkg.sv
// Shared types for the sequential add/accumulate unit: operation codes and FSM states.
package seq_add_accum_pkg;

  // Operation selector, sampled on the first beat of an operation.
  typedef enum logic [1:0] {
    MODE_ADD     = 2'b00,
    MODE_SUB     = 2'b01,
    MODE_ACC     = 2'b10,
    MODE_ABSDIFF = 2'b11
  } mode_t;

  // Control FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_add_accum_if.sv
// Operand stream in, result stream out. The slave side is the arithmetic unit.
interface seq_add_accum_if
  import seq_add_accum_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  mode_t            mode;
  logic [CNT_W-1:0] len;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, mode, len, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, mode, len, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_ovf
  );
endinterface

// File: rtl/seq_add_accum_sat_add_sub.sv
// Combinational add or subtract with optional clamping. y is one bit wider than x so
// that an operand pair sum (a+b) can be added to a running value in a single step.
module sat_add_sub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH:0]   y,
  input  logic             subtract,
  input  logic             saturate,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             add_over;

  assign sum      = {2'b00, x} + {1'b0, y};
  assign diff     = x - y[WIDTH-1:0];
  assign borrow   = {1'b0, x} < y;
  assign add_over = |sum[WIDTH+1:WIDTH];

  // Select add or subtract result; clamp to the range ends when saturating.
  always_comb begin
    if (subtract) begin
      result   = (saturate && borrow) ? '0 : diff;
      carry    = borrow;
      overflow = borrow;
    end else begin
      result   = (saturate && add_over) ? '1 : sum[WIDTH-1:0];
      carry    = add_over;
      overflow = add_over;
    end
  end
endmodule

// File: rtl/seq_add_accum.sv
// Handshaked arithmetic unit: ADD / SUB / ABSDIFF in one beat, ACC over len+1 beats.
// The result sits in a one-entry output register until the consumer takes it.
module seq_add_accum
  import seq_add_accum_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CNT_W    = 4,
  parameter bit SATURATE = 1'b0
) (
  input logic            clk,
  input logic            rst_n,
  seq_add_accum_if.slave bus
);
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic             acc_ovf_reg, acc_ovf_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic             out_carry_reg, out_carry_next;
  logic             out_ovf_reg, out_ovf_next;

  logic             accept;
  logic             a_lt_b;
  logic             swap;
  logic [WIDTH:0]   pair_sum;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] sub_x;
  logic [WIDTH:0]   sub_y;
  logic [WIDTH-1:0] add_res, sub_res;
  logic             add_carry, add_ovf, sub_borrow, sub_ovf;

  assign bus.in_ready  = rst_n && (state_reg != S_HOLD);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_reg == S_HOLD);
  assign bus.out_data  = out_data_reg;
  assign bus.out_carry = out_carry_reg;
  assign bus.out_ovf   = out_ovf_reg;

  // ABSDIFF reuses the subtractor with operands ordered so the result is never negative.
  assign a_lt_b   = bus.in_a < bus.in_b;
  assign swap     = (bus.mode == MODE_ABSDIFF) && a_lt_b;
  assign sub_x    = swap ? bus.in_b : bus.in_a;
  assign sub_y    = {1'b0, (swap ? bus.in_a : bus.in_b)};
  assign pair_sum = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  // Single-beat ops and the first ACC beat start from zero; later beats add onto acc.
  assign add_x    = (state_reg == S_ACCUM) ? acc_reg : '0;

  sat_add_sub #(.WIDTH(WIDTH)) u_add (
    .x        (add_x),
    .y        (pair_sum),
    .subtract (1'b0),
    .saturate (SATURATE),
    .result   (add_res),
    .carry    (add_carry),
    .overflow (add_ovf)
  );

  sat_add_sub #(.WIDTH(WIDTH)) u_sub (
    .x        (sub_x),
    .y        (sub_y),
    .subtract (1'b1),
    .saturate (SATURATE),
    .result   (sub_res),
    .carry    (sub_borrow),
    .overflow (sub_ovf)
  );

  // Next-state, accumulator and result-register loading.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    acc_next       = acc_reg;
    acc_ovf_next   = acc_ovf_reg;
    out_data_next  = out_data_reg;
    out_carry_next = out_carry_reg;
    out_ovf_next   = out_ovf_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          case (bus.mode)
            MODE_ADD: begin
              out_data_next  = add_res;
              out_carry_next = add_carry;
              out_ovf_next   = add_ovf;
              state_next     = S_HOLD;
            end
            MODE_SUB: begin
              out_data_next  = sub_res;
              out_carry_next = sub_borrow;
              out_ovf_next   = sub_ovf;
              state_next     = S_HOLD;
            end
            MODE_ABSDIFF: begin
              out_data_next  = sub_res;
              out_carry_next = a_lt_b;
              out_ovf_next   = 1'b0;
              state_next     = S_HOLD;
            end
            MODE_ACC: begin
              if (bus.len == '0) begin
                out_data_next  = add_res;
                out_carry_next = add_carry;
                out_ovf_next   = add_ovf;
                state_next     = S_HOLD;
              end else begin
                acc_next     = add_res;
                acc_ovf_next = add_ovf;
                cnt_next     = bus.len;
                state_next   = S_ACCUM;
              end
            end
            default: state_next = S_IDLE;
          endcase
        end
      end
      S_ACCUM: begin
        if (accept) begin
          acc_next     = add_res;
          acc_ovf_next = acc_ovf_reg | add_ovf;
          cnt_next     = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            out_data_next  = add_res;
            out_carry_next = add_carry;
            out_ovf_next   = acc_ovf_reg | add_ovf;
            state_next     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (bus.out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      acc_ovf_reg   <= 1'b0;
      out_data_reg  <= '0;
      out_carry_reg <= 1'b0;
      out_ovf_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      acc_ovf_reg   <= acc_ovf_next;
      out_data_reg  <= out_data_next;
      out_carry_reg <= out_carry_next;
      out_ovf_reg   <= out_ovf_next;
    end
  end
endmodule

// File: tb/tb_seq_add_accum.sv
// Directed bench: a wrapping and a saturating instance driven in lockstep with the
// same operand stream, each checked against hand-computed results.
module tb_seq_add_accum;
  import seq_add_accum_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_a;
  logic [3:0] in_b;
  mode_t      mode;
  logic [3:0] len;
  logic       out_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_add_accum_if #(.WIDTH(4), .CNT_W(4)) bus_w ();
  seq_add_accum_if #(.WIDTH(4), .CNT_W(4)) bus_s ();

  assign bus_w.in_valid  = in_valid;
  assign bus_w.in_a      = in_a;
  assign bus_w.in_b      = in_b;
  assign bus_w.mode      = mode;
  assign bus_w.len       = len;
  assign bus_w.out_ready = out_ready;
  assign bus_s.in_valid  = in_valid;
  assign bus_s.in_a      = in_a;
  assign bus_s.in_b      = in_b;
  assign bus_s.mode      = mode;
  assign bus_s.len       = len;
  assign bus_s.out_ready = out_ready;

  seq_add_accum #(.WIDTH(4), .CNT_W(4), .SATURATE(1'b0)) u_dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  seq_add_accum #(.WIDTH(4), .CNT_W(4), .SATURATE(1'b1)) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one beat and wait (bounded) for the accepting edge; returns edges waited.
  task automatic send_beat(input int a, input int b, input mode_t m, input int l,
                           output int waited);
    logic rdy;
    bit   got;
    in_valid = 1'b1;
    in_a     = 4'(a);
    in_b     = 4'(b);
    mode     = m;
    len      = 4'(l);
    got      = 1'b0;
    waited   = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      rdy = bus_w.in_ready;
      @(posedge clk);
      #1;
      waited++;
      if (rdy) got = 1'b1;
    end
    if (!got) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // Compare the held result of both instances, one line per completed operation.
  task automatic check_result(input string tag, input int dw, input int ds,
                              input int c, input int o);
    check({tag, ".valid_w"}, int'(bus_w.out_valid), 1);
    check({tag, ".valid_s"}, int'(bus_s.out_valid), 1);
    check({tag, ".data_w"},  int'(bus_w.out_data),  dw);
    check({tag, ".data_s"},  int'(bus_s.out_data),  ds);
    check({tag, ".carry_w"}, int'(bus_w.out_carry), c);
    check({tag, ".carry_s"}, int'(bus_s.out_carry), c);
    check({tag, ".ovf_w"},   int'(bus_w.out_ovf),   o);
    check({tag, ".ovf_s"},   int'(bus_s.out_ovf),   o);
    $display("op %s: wrap data=%0d sat data=%0d carry=%0d ovf=%0d", tag,
             bus_w.out_data, bus_s.out_data, bus_w.out_carry, bus_w.out_ovf);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".released"}, int'(bus_w.out_valid), 0);
    check({tag, ".ready_after"}, int'(bus_w.in_ready), 1);
  endtask

  initial begin
    int w;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_a      = 4'd9;
    in_b      = 4'd8;
    mode      = MODE_ADD;
    len       = 4'd0;
    out_ready = 1'b0;

    // Reset held 3 cycles with a beat offered: nothing accepted, outputs zero.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst.in_ready", int'(bus_w.in_ready), 0);
      check("rst.out_valid", int'(bus_w.out_valid), 0);
      check("rst.out_data", int'(bus_s.out_data), 0);
      check("rst.carry_ovf", int'({bus_w.out_carry, bus_w.out_ovf}), 0);
    end
    rst_n = 1'b1;

    // ADD 9+8: first beat after reset accepted, result held 3 cycles under backpressure.
    send_beat(9, 8, MODE_ADD, 0, w);
    check("add.accept_edges", w, 1);
    check_result("add_9_8", 1, 15, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("add.hold_valid", int'(bus_w.out_valid), 1);
      check("add.hold_data", int'(bus_w.out_data), 1);
      check("add.hold_ready", int'(bus_w.in_ready), 0);
    end
    release_result("add_9_8");

    // SUB 3-7 with in_valid held through HOLD carrying the next op (ABSDIFF 3,7).
    send_beat(3, 7, MODE_SUB, 0, w);
    in_valid = 1'b1;
    mode     = MODE_ABSDIFF;
    check_result("sub_3_7", 12, 0, 1, 1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("bp.hold_data", int'(bus_w.out_data), 12);
      check("bp.hold_ready", int'(bus_w.in_ready), 0);
    end
    release_result("sub_3_7");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_result("absdiff_3_7", 4, 4, 1, 0);
    release_result("absdiff_3_7");

    // ACC len=2 with a one-cycle gap: 1+2+3+4+0+1 = 11.
    send_beat(1, 2, MODE_ACC, 2, w);
    @(posedge clk);
    #1;
    check("acc.mid_valid", int'(bus_w.out_valid), 0);
    send_beat(3, 4, MODE_ADD, 9, w);
    check("acc.mid_valid2", int'(bus_w.out_valid), 0);
    send_beat(0, 1, MODE_SUB, 5, w);
    check_result("acc_11", 11, 11, 0, 0);
    check("acc.hold_ready", int'(bus_w.in_ready), 0);
    release_result("acc_11");

    // ACC len=2 ending in an overflowing step: 3, 10, 24.
    send_beat(1, 2, MODE_ACC, 2, w);
    send_beat(3, 4, MODE_ACC, 0, w);
    send_beat(7, 7, MODE_ACC, 0, w);
    check_result("acc_ovf", 8, 15, 1, 1);
    release_result("acc_ovf");

    // ACC len=0 behaves as a single add.
    send_beat(5, 6, MODE_ACC, 0, w);
    check_result("acc_len0", 11, 11, 0, 0);
    release_result("acc_len0");

    // Overflow on first beat stays sticky; a clamped accumulator stays clamped.
    send_beat(9, 9, MODE_ACC, 1, w);
    send_beat(0, 0, MODE_ACC, 0, w);
    check_result("acc_sticky", 2, 15, 0, 1);
    release_result("acc_sticky");

    // Reset after 1 of 3 ACC beats, then ADD 2+2 must not see the old accumulator.
    send_beat(5, 5, MODE_ACC, 2, w);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst.in_ready", int'(bus_w.in_ready), 0);
    check("midrst.out_valid", int'(bus_w.out_valid), 0);
    check("midrst.out_data", int'(bus_s.out_data), 0);
    rst_n = 1'b1;
    send_beat(2, 2, MODE_ADD, 0, w);
    check("midrst.accept_edges", w, 1);
    check_result("add_2_2", 4, 4, 0, 0);
    release_result("add_2_2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
